// File: rtl/div_ctrl.sv
// Iterative radix-2 restoring divide sequencer for DIV/DIVU in EX; result is {HI=remainder, LO=quotient}.
// Latency: DATA_W+1 cycles from accepted start to ready (2 cycles for a zero divisor); result held while start stays high.
// Backpressure: stallreq_o holds the pipeline from the start cycle until ready; flush or a dropped start aborts to idle.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   div_start_i         EX holds a divide; operands stable until ready
//   div_signed_i        1 = signed DIV, 0 = unsigned DIVU
//   opdata1_i/2_i       dividend / divisor
//   flush_i             abort the current operation
//   div_result_o        {remainder, quotient}, zero unless ready
//   div_ready_o         result valid this cycle
//   stallreq_o          stall request to the pipeline controller
module div_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                div_start_i,
    input  logic                div_signed_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                flush_i,
    output logic [2*DATA_W-1:0] div_result_o,
    output logic                div_ready_o,
    output logic                stallreq_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ZERO = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   count_q;
    logic [DATA_W-1:0]  rem_q;
    logic [DATA_W-1:0]  quo_q;
    logic [DATA_W-1:0]  dvs_q;
    logic               quo_neg_q;
    logic               rem_neg_q;

    logic               go;
    logic               keep;
    logic [DATA_W-1:0]  op1_mag;
    logic [DATA_W-1:0]  op2_mag;
    logic [DATA_W:0]    rem_sh;
    logic [DATA_W:0]    trial;
    logic [DATA_W-1:0]  rem_fix;
    logic [DATA_W-1:0]  quo_fix;

    // Accept a new operation only from IDLE; flush beats a same-cycle start.
    assign go   = div_start_i & ~flush_i;
    // An operation in flight survives the edge only while start is held and no flush.
    assign keep = div_start_i & ~flush_i;

    // Magnitudes; the most negative value maps onto itself, which is the correct unsigned magnitude.
    assign op1_mag = (div_signed_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    assign op2_mag = (div_signed_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

    // Restoring step: shift the next dividend bit into the partial remainder and try the subtract.
    // The partial remainder is always below the divisor, so DATA_W+1 bits hold the trial exactly.
    assign rem_sh = {rem_q, quo_q[DATA_W-1]};
    assign trial  = rem_sh - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = (opdata2_i == '0) ? ZERO : BUSY;
                end
            end
            ZERO: begin
                state_d = keep ? DONE : IDLE;
            end
            BUSY: begin
                if (!keep) begin
                    state_d = IDLE;
                end else if (count_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Never restarts from here; EX must drop start between operations.
                if (!keep) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go) begin
                        count_q <= '0;
                        if (opdata2_i == '0) begin
                            // Fixed divide-by-zero answer, presented without sign correction.
                            rem_q     <= opdata1_i;
                            quo_q     <= '1;
                            quo_neg_q <= 1'b0;
                            rem_neg_q <= 1'b0;
                        end else begin
                            rem_q     <= '0;
                            quo_q     <= op1_mag;
                            dvs_q     <= op2_mag;
                            quo_neg_q <= div_signed_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                            rem_neg_q <= div_signed_i & opdata1_i[DATA_W-1];
                        end
                    end
                end
                BUSY: begin
                    if (keep) begin
                        quo_q   <= {quo_q[DATA_W-2:0], ~trial[DATA_W]};
                        rem_q   <= trial[DATA_W] ? rem_sh[DATA_W-1:0] : trial[DATA_W-1:0];
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rem_fix = rem_neg_q ? (~rem_q + 1'b1) : rem_q;
    assign quo_fix = quo_neg_q ? (~quo_q + 1'b1) : quo_q;

    assign div_ready_o  = (state_q == DONE);
    assign div_result_o = div_ready_o ? {rem_fix, quo_fix} : '0;
    // Combinational so the stall covers the start cycle itself; held low during reset.
    assign stallreq_o   = div_start_i & (state_q != DONE) & ~flush_i & ~rst;

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        div_start_i;
    logic        div_signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        flush_i;
    logic [63:0] div_result_o;
    logic        div_ready_o;
    logic        stallreq_o;

    div_ctrl #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .div_start_i  (div_start_i),
        .div_signed_i (div_signed_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .flush_i      (flush_i),
        .div_result_o (div_result_o),
        .div_ready_o  (div_ready_o),
        .stallreq_o   (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int t0    = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Arithmetic reference: truncating division, remainder takes the dividend's sign.
    function automatic logic [63:0] exp_div(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint sx;
        longint sy;
        longint q;
        longint r;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'({32'd0, x});
            sy = longint'({32'd0, y});
        end
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    // Timeline model: an accepted operation becomes ready a fixed number of cycles later
    // and stays ready while start is held; flush or a dropped start cancels everything.
    logic        m_busy;
    logic        m_done;
    int          m_age;
    int          m_lat;
    logic [63:0] m_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_age  = 0;
        end else if (flush_i || !div_start_i) begin
            m_busy = 1'b0;
            m_done = 1'b0;
        end else if (!m_busy && !m_done) begin
            m_busy = 1'b1;
            m_age  = 1;
            m_lat  = (opdata2_i == 32'd0) ? 2 : 33;
            m_res  = exp_div(opdata1_i, opdata2_i, div_signed_i);
        end else if (m_busy) begin
            m_age++;
            if (m_age == m_lat) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("model_ready", {63'd0, div_ready_o}, {63'd0, m_done});
        check("model_stall", {63'd0, stallreq_o},
              {63'd0, div_start_i & ~m_done & ~flush_i & ~rst});
        check("model_result", div_result_o, m_done ? m_res : 64'd0);
    end

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(posedge clk);
        #1;
        opdata1_i    = a;
        opdata2_i    = b;
        div_signed_i = s;
        div_start_i  = 1'b1;
        t0           = cyc;
    endtask

    task automatic wait_ready(input string name, output int lat, output int stall_n);
        int n;
        n       = 0;
        stall_n = 0;
        @(negedge clk);
        while (!div_ready_o && n < 200) begin
            if (stallreq_o) stall_n++;
            @(negedge clk);
            n++;
        end
        if (!div_ready_o) check({name, "_timeout"}, 64'd0, 64'd1);
        lat = cyc - t0;
    endtask

    task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] hi, input logic [31:0] lo,
                          input int exp_lat);
        int lat;
        int sn;
        start_op(a, b, s);
        wait_ready(name, lat, sn);
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_stall_cycles"}, 64'(sn), 64'(exp_lat));
        check({name, "_result"}, div_result_o, {hi, lo});
        repeat (2) @(negedge clk);
        check({name, "_held"}, {div_result_o[63:1], div_ready_o}, {hi, lo[31:1], 1'b1});
        @(posedge clk);
        #1;
        div_start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({name, "_ready_dropped"}, {63'd0, div_ready_o}, 64'd0);
    endtask

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int lat;
        int sn;
        vecs[0] = '{"divu_100_7",    32'd100,        32'd7,          1'b0, 32'd2,          32'd14,         33};
        vecs[1] = '{"div_m7_2",      32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFD,  33};
        vecs[2] = '{"div_7_m2",      32'd7,          32'hFFFF_FFFE,  1'b1, 32'd1,          32'hFFFF_FFFD,  33};
        vecs[3] = '{"divu_max_1",    32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0,          32'hFFFF_FFFF,  33};
        vecs[4] = '{"div_ovf",       32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'd0,          32'h8000_0000,  33};
        vecs[5] = '{"divu_min_max",  32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000,  32'd0,          33};
        vecs[6] = '{"div_m100_m7",   32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'hFFFF_FFFE,  32'd14,         33};
        vecs[7] = '{"divz_1234",     32'h0000_1234,  32'd0,          1'b0, 32'h0000_1234,  32'hFFFF_FFFF,  2};
        vecs[8] = '{"divz_signed",   32'hFFFF_FF00,  32'd0,          1'b1, 32'hFFFF_FF00,  32'hFFFF_FFFF,  2};

        rst          = 1'b1;
        div_start_i  = 1'b0;
        div_signed_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        flush_i      = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_outputs", {div_result_o, 62'd0} | {63'd0, div_ready_o},  128'd0 >> 64);
        check("reset_stall", {63'd0, stallreq_o}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_div(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].hi, vecs[i].lo, vecs[i].lat);
        end

        // Flush mid-divide, then a fresh divide two cycles later.
        start_op(32'd50, 32'd5, 1'b0);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        flush_i = 1'b1;
        @(negedge clk);
        check("flush_stall_low", {63'd0, stallreq_o}, 64'd0);
        @(posedge clk);
        #1;
        flush_i     = 1'b0;
        div_start_i = 1'b0;
        @(negedge clk);
        check("flush_no_ready", {63'd0, div_ready_o}, 64'd0);
        @(posedge clk);
        #1;
        opdata1_i   = 32'd9;
        opdata2_i   = 32'd3;
        div_start_i = 1'b1;
        wait_ready("after_flush", lat, sn);
        check("after_flush_at_T45", 64'(lat), 64'd45);
        check("after_flush_result", div_result_o, {32'd0, 32'd3});
        @(posedge clk);
        #1;
        div_start_i = 1'b0;
        @(posedge clk);

        // Flush beats a start in the same cycle; the start is accepted one cycle later.
        @(posedge clk);
        #1;
        opdata1_i    = 32'd21;
        opdata2_i    = 32'd4;
        div_signed_i = 1'b0;
        div_start_i  = 1'b1;
        flush_i      = 1'b1;
        @(negedge clk);
        check("flush_start_stall", {63'd0, stallreq_o}, 64'd0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        t0      = cyc;
        wait_ready("flush_start", lat, sn);
        check("flush_start_latency", 64'(lat), 64'd33);
        check("flush_start_result", div_result_o, {32'd1, 32'd5});
        @(posedge clk);
        #1;
        div_start_i = 1'b0;
        @(posedge clk);

        // Dropping start mid-divide aborts.
        start_op(32'd77, 32'd7, 1'b0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        div_start_i = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_ready", {63'd0, div_ready_o}, 64'd0);

        // Asynchronous reset in the middle of a divide.
        start_op(32'd1000, 32'd10, 1'b0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("rst_result_zero", div_result_o, 64'd0);
        check("rst_ready_stall_zero", {62'd0, div_ready_o, stallreq_o}, 64'd0);
        @(posedge clk);
        #1;
        div_start_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_div("after_rst", 32'd1000, 32'd10, 1'b0, 32'd0, 32'd100, 33);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
